lcd_sequencer: RTL and testbench
================================

// Module: lcd_sequencer
// PURPOSE
//  Consumer stage for the LCD command ROM: steps the ROM index, decodes each
//  12-bit {cmd[3:0], payload[7:0]} word and drives the HD44780 character LCD
//  pins with correct timing. Also runs the power-up init. Sits between the
//  command ROM and the board LCD pins.
//  After a clear command, playback loops back to index 0.
// PARAMETERS
//  T_PWRUP_CYC  1_000_000    power-up quiet time before init (20 ms @ 50 MHz)
//  T_EN_CYC     25           LCD_EN high width in clocks
//  T_CMD_CYC    2_500        settle after EN fall, normal write/instr (50 us)
//  T_CLR_CYC    100_000      settle after EN fall, clear instr (2 ms)
//  T_WAIT2_CYC  100_000_000  duration of a wait2 command (2 s)
//  CNT_W        27           delay counter width; must hold the largest T_*
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  run       in   1   1 = play ROM; 0 = halt after the current operation
//  cmd_data  in   12  ROM word for cmd_idx, {cmd, payload}
//  cmd_idx   out  32  ROM index
//  busy      out  1   1 while init or an operation is in progress
//  LCD_ON    out  1   panel power, 1 after reset release
//  LCD_RS    out  1   0 = instruction, 1 = data
//  LCD_RW    out  1   tied 0 (write only)
//  LCD_EN    out  1   enable strobe
//  LCD_DATA  out  8   data bus
// BEHAVIOUR
//  Reset:
//   - All outputs are 0 and cmd_idx=0; state is PWRUP.
//   - Reset is async, so LCD_EN drops in the same instant rst_n falls.
//  Cmd codes (lcd_defs.vh): clear=0000, write=0001, setad=0011, wait2=0100.
//  FSM states: PWRUP, INIT, FETCH, DECODE, STROBE, SETTLE, DELAY, IDLE.
//   - PWRUP: LCD_ON=1; count T_PWRUP_CYC, then INIT.
//   - INIT: strobes 0x38, 0x0C, 0x06, 0x01 with RS=0; settle is T_CMD_CYC,
//     or T_CLR_CYC for 0x01. Then FETCH with cmd_idx=0.
//   - FETCH: one cycle; the ROM is combinational, so cmd_data is registered
//     at the end of this cycle.
//   - DECODE: acts on the registered command.
//     - write: RS=1, byte=payload.
//     - setad (payload p = linear DDRAM position, 0..39 line 1, 40..79 line 2):
//       RS=0, byte = 0x80|(p<40 ? p : p+24); p>=80 gives byte 0x80.
//     - clear: RS=0, byte=0x01.
//     - wait2: go to DELAY for T_WAIT2_CYC, no bus activity.
//     - any other code: no-op, cmd_idx+1, back to FETCH (2 cycles total).
//   - STROBE: RS/DATA are driven one cycle before EN rises (setup), then
//     EN=1 for exactly T_EN_CYC cycles. RS/DATA are held until the next
//     strobe.
//   - SETTLE: count from EN fall (T_CLR_CYC for clear, else T_CMD_CYC).
//     At end: clear sets cmd_idx=0, all others set cmd_idx+1.
//     Then FETCH if run=1, else IDLE.
//   - IDLE: busy=0, cmd_idx frozen; run=1 goes to FETCH.
//  run:
//   - Sampled only at operation boundaries; never aborts a strobe or a delay.
//   - run is ignored during PWRUP and INIT.
//  busy=1 in every state except IDLE.
//  cmd_idx wraps modulo 2^32; in practice the ROM default (clear) returns it to 0.
//  Reset mid-operation: FSM aborts and the full PWRUP+INIT replays on release.
// STRUCTURE
//  - lcd_defs.vh: cmd codes, init bytes, ROM word field positions; shared with
//    the command ROM.
//  - Sub-module lcd_strobe: inputs go, rs, byte, settle_cyc; outputs done
//    (1-cycle pulse), EN/RS/DATA. Owns setup, EN width and settle counting.
//  - Top level holds the FSM, init step counter, index and wait2 delay.
// TESTING  (T_PWRUP=10, T_EN=2, T_CMD=5, T_CLR=20, T_WAIT2=50)
//  1 Release rst_n, run=1 -> EN stays 0 for 10 cycles; then strobes 38,0C,06,01
//    with RS=0; gap after 01 >=20 cycles; cmd_idx=0 on first FETCH.
//  2 ROM word {0011,d4} -> byte 0x84 RS=0; {0011,d43} -> 0xC3;
//    {0011,d90} -> 0x80.
//  3 ROM word {0001,0x57} -> RS=1, DATA=0x57 one cycle before EN; EN high
//    exactly 2 cycles; next EN rise >=5 cycles after fall.
//  4 wait2 at idx 20 -> no EN for 50 cycles, idx 20->21; clear at 21 -> byte
//    0x01, 20-cycle settle, idx returns to 0.
//  5 rst_n low while EN=1 -> EN=0 asynchronously, all outputs 0; on release
//    test 1 behaviour repeats.
//  6 run=0 during a write -> write completes, idx advances once, busy=0, idx
//    frozen. Then illegal cmd 0111 -> idx+1 in 2 cycles, no strobe.

Source files
------------

// File: rtl/lcd_sequencer_pkg.sv
// lcd_sequencer_pkg: command codes, FSM state types and byte helpers for the LCD sequencer
package lcd_sequencer_pkg;
   localparam logic [3:0] CMD_CLEAR = 4'b0000;
   localparam logic [3:0] CMD_WRITE = 4'b0001;
   localparam logic [3:0] CMD_SETAD = 4'b0011;
   localparam logic [3:0] CMD_WAIT2 = 4'b0100;
   typedef enum logic [2:0] {PWRUP, INIT, FETCH, DECODE, STROBE, SETTLE, DELAY, IDLE} state_t;
   typedef enum logic [1:0] {SB_IDLE, SB_SETUP, SB_EN, SB_SETTLE} strobe_t;
   function automatic logic [7:0] init_byte(input logic [1:0] s);
      return s == 2'd0 ? 8'h38 : s == 2'd1 ? 8'h0C : s == 2'd2 ? 8'h06 : 8'h01;
   endfunction
   // line 2 of the panel starts at DDRAM 0x40, so linear positions 40..79 skip 24 addresses
   function automatic logic [7:0] setad_byte(input logic [7:0] p);
      return p < 8'd40 ? 8'h80 | p : p < 8'd80 ? 8'h80 | (p + 8'd24) : 8'h80;
   endfunction
endpackage

// File: rtl/lcd_sequencer_strobe.sv
// lcd_strobe: one LCD bus write -- setup cycle, EN pulse, then settle delay
//   go         in   start a write when idle (rs/data/settle_cyc latched)
//   rs, data   in   register select and bus byte for this write
//   settle_cyc in   clocks to wait after EN falls
//   done       out  1-cycle pulse when settle finishes
//   lcd_en/lcd_rs/lcd_data out  pin drives; rs/data held until the next go
module lcd_strobe
   import lcd_sequencer_pkg::*;
#(
   parameter int T_EN_CYC = 25,
   parameter int CNT_W    = 27
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic             rs,
   input  logic [7:0]       data,
   input  logic [CNT_W-1:0] settle_cyc,
   output logic             done,
   output logic             lcd_en,
   output logic             lcd_rs,
   output logic [7:0]       lcd_data
);
   strobe_t          sb, sb_d;
   logic [CNT_W-1:0] cnt, cnt_d, settle_q, settle_d;
   logic             en_d, rs_d, done_d;
   logic [7:0]       data_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sb       <= SB_IDLE;
         cnt      <= '0;
         settle_q <= '0;
         lcd_en   <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= '0;
         done     <= 1'b0;
      end else begin
         sb       <= sb_d;
         cnt      <= cnt_d;
         settle_q <= settle_d;
         lcd_en   <= en_d;
         lcd_rs   <= rs_d;
         lcd_data <= data_d;
         done     <= done_d;
      end
   always_comb begin
      sb_d     = sb;
      cnt_d    = cnt + CNT_W'(1);
      settle_d = settle_q;
      en_d     = lcd_en;
      rs_d     = lcd_rs;
      data_d   = lcd_data;
      done_d   = 1'b0;
      case (sb)
         SB_IDLE: if (go) begin
            sb_d     = SB_SETUP;
            rs_d     = rs;
            data_d   = data;
            settle_d = settle_cyc;
         end
         SB_SETUP: begin
            sb_d  = SB_EN;
            en_d  = 1'b1;
            cnt_d = '0;
         end
         SB_EN: if (cnt == CNT_W'(T_EN_CYC - 1)) begin
            sb_d  = SB_SETTLE;
            en_d  = 1'b0;
            cnt_d = '0;
         end
         SB_SETTLE: if (cnt == settle_q - CNT_W'(1)) begin
            sb_d   = SB_IDLE;
            done_d = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: plays the LCD command ROM onto HD44780 pins after power-up init
//   clk, rst_n   clock, async active-low reset
//   run          1 = play ROM, 0 = stop at the next operation boundary
//   cmd_data     ROM word {cmd[3:0], payload[7:0]} at cmd_idx
//   cmd_idx      ROM index
//   busy         0 only when halted in IDLE
//   LCD_ON/RS/RW/EN/DATA   panel pins
module lcd_sequencer
   import lcd_sequencer_pkg::*;
#(
   parameter int T_PWRUP_CYC = 1_000_000,
   parameter int T_EN_CYC    = 25,
   parameter int T_CMD_CYC   = 2_500,
   parameter int T_CLR_CYC   = 100_000,
   parameter int T_WAIT2_CYC = 100_000_000,
   parameter int CNT_W       = 27
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [11:0] cmd_data,
   output logic [31:0] cmd_idx,
   output logic        busy,
   output logic        LCD_ON,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic        LCD_EN,
   output logic [7:0]  LCD_DATA
);
   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d, go_settle;
   logic [31:0]      idx_d;
   logic [2:0]       step, step_d;
   logic [11:0]      cmd_q;
   logic             go, go_rs, done;
   logic [7:0]       go_data;
   assign LCD_RW = 1'b0;
   lcd_strobe #(.T_EN_CYC(T_EN_CYC), .CNT_W(CNT_W)) u_strobe (
      .clk        (clk),
      .rst_n      (rst_n),
      .go         (go),
      .rs         (go_rs),
      .data       (go_data),
      .settle_cyc (go_settle),
      .done       (done),
      .lcd_en     (LCD_EN),
      .lcd_rs     (LCD_RS),
      .lcd_data   (LCD_DATA)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= PWRUP;
         cnt     <= '0;
         cmd_idx <= '0;
         step    <= '0;
         cmd_q   <= '0;
         busy    <= 1'b0;
         LCD_ON  <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         cmd_idx <= idx_d;
         step    <= step_d;
         cmd_q   <= state == FETCH ? cmd_data : cmd_q;
         busy    <= state_d != IDLE;
         LCD_ON  <= 1'b1;
      end
   // step counts the four init writes; step[2] set means init is finished
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      idx_d     = cmd_idx;
      step_d    = step;
      go        = 1'b0;
      go_rs     = 1'b0;
      go_data   = cmd_q[7:0];
      go_settle = CNT_W'(T_CMD_CYC);
      case (state)
         PWRUP: begin
            cnt_d   = cnt == CNT_W'(T_PWRUP_CYC - 1) ? '0 : cnt + CNT_W'(1);
            state_d = cnt == CNT_W'(T_PWRUP_CYC - 1) ? INIT : PWRUP;
         end
         INIT: if (step[2]) begin
            idx_d   = '0;
            state_d = FETCH;
         end else begin
            go        = 1'b1;
            go_data   = init_byte(step[1:0]);
            go_settle = step[1:0] == 2'd3 ? CNT_W'(T_CLR_CYC) : CNT_W'(T_CMD_CYC);
            state_d   = STROBE;
         end
         FETCH: state_d = DECODE;
         DECODE: case (cmd_q[11:8])
            CMD_WRITE: begin
               go      = 1'b1;
               go_rs   = 1'b1;
               state_d = STROBE;
            end
            CMD_SETAD: begin
               go      = 1'b1;
               go_data = setad_byte(cmd_q[7:0]);
               state_d = STROBE;
            end
            CMD_CLEAR: begin
               go        = 1'b1;
               go_data   = 8'h01;
               go_settle = CNT_W'(T_CLR_CYC);
               state_d   = STROBE;
            end
            CMD_WAIT2: begin
               cnt_d   = '0;
               state_d = DELAY;
            end
            default: begin
               idx_d   = cmd_idx + 32'd1;
               state_d = FETCH;
            end
         endcase
         STROBE: state_d = LCD_EN ? SETTLE : STROBE;
         SETTLE: if (done) begin
            if (!step[2]) begin
               step_d  = step + 3'd1;
               state_d = INIT;
            end else begin
               idx_d   = cmd_q[11:8] == CMD_CLEAR ? '0 : cmd_idx + 32'd1;
               state_d = run ? FETCH : IDLE;
            end
         end
         DELAY: begin
            cnt_d = cnt + CNT_W'(1);
            if (cnt == CNT_W'(T_WAIT2_CYC - 1)) begin
               cnt_d   = '0;
               idx_d   = cmd_idx + 32'd1;
               state_d = run ? FETCH : IDLE;
            end
         end
         IDLE: state_d = run ? FETCH : IDLE;
      endcase
   end
endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: scoreboard bench for lcd_sequencer with short timing parameters
module tb_lcd_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0;
   logic [11:0] cmd_data;
   logic [31:0] cmd_idx;
   logic        busy, lcd_on, lcd_rs, lcd_rw, lcd_en;
   logic [7:0]  lcd_data;
   logic [11:0] rom [0:31];
   typedef struct {
      logic        rs;
      logic [7:0]  data;
      logic [31:0] idx;
      bit          setup_ok;
      int          gap;
      int          rise_cyc;
      int          width;
      bit          closed;
   } obs_t;
   typedef struct {
      logic        rs;
      logic [7:0]  data;
      logic [31:0] idx;
      int          min_gap;
   } exp_t;
   obs_t obs [0:63];
   exp_t exp_q [$];
   int   obs_n = 0, cyc = 0, fall_cyc = 0, hi = 0;
   logic en_p = 1'b0, rs_p = 1'b0;
   logic [7:0] data_p = 8'h00;
   int   n_chk = 0, n_fail = 0, rd = 0, rel_cyc = 0, n0 = 0, r = 0;
   assign cmd_data = cmd_idx < 32'd32 ? rom[cmd_idx[4:0]] : 12'h000;
   always #5 clk = ~clk;
   lcd_sequencer #(
      .T_PWRUP_CYC (10),
      .T_EN_CYC    (2),
      .T_CMD_CYC   (5),
      .T_CLR_CYC   (20),
      .T_WAIT2_CYC (50),
      .CNT_W       (27)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .cmd_data (cmd_data),
      .cmd_idx  (cmd_idx),
      .busy     (busy),
      .LCD_ON   (lcd_on),
      .LCD_RS   (lcd_rs),
      .LCD_RW   (lcd_rw),
      .LCD_EN   (lcd_en),
      .LCD_DATA (lcd_data)
   );
   // bus monitor: records every EN pulse with the bus state around it
   always @(negedge clk) begin
      cyc++;
      if (lcd_en === 1'b1 && en_p !== 1'b1 && obs_n < 64) begin
         obs[obs_n].rs       = lcd_rs;
         obs[obs_n].data     = lcd_data;
         obs[obs_n].idx      = cmd_idx;
         obs[obs_n].setup_ok = lcd_rs === rs_p && lcd_data === data_p;
         obs[obs_n].gap      = cyc - fall_cyc;
         obs[obs_n].rise_cyc = cyc;
         obs[obs_n].width    = 0;
         obs[obs_n].closed   = 1'b0;
         obs_n++;
         hi = 0;
      end
      if (lcd_en === 1'b1) hi++;
      if (lcd_en !== 1'b1 && en_p === 1'b1 && obs_n > 0) begin
         obs[obs_n-1].width  = hi;
         obs[obs_n-1].closed = 1'b1;
         fall_cyc = cyc;
      end
      en_p   = lcd_en;
      rs_p   = lcd_rs;
      data_p = lcd_data;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask
   task automatic push(input logic rs, input logic [7:0] data, input logic [31:0] idx, input int min_gap);
      exp_t e;
      e.rs = rs; e.data = data; e.idx = idx; e.min_gap = min_gap;
      exp_q.push_back(e);
   endtask
   task automatic next_strobe(input string tag, input bit full);
      exp_t e;
      int   i;
      bit   ok;
      i = 0;
      while (i < 400 && !(rd < obs_n && obs[rd].closed)) begin
         @(posedge clk);
         i++;
      end
      e  = exp_q.pop_front();
      ok = rd < obs_n && obs[rd].closed;
      chk({tag, "_seen"}, 32'(ok), 32'd1);
      if (ok) begin
         chk({tag, "_rs"}, 32'(obs[rd].rs), 32'(e.rs));
         chk({tag, "_data"}, 32'(obs[rd].data), 32'(e.data));
         chk({tag, "_idx"}, obs[rd].idx, e.idx);
         chk({tag, "_setup"}, 32'(obs[rd].setup_ok), 32'd1);
         chk({tag, "_gap"}, 32'(obs[rd].gap >= e.min_gap), 32'd1);
         if (full) chk({tag, "_width"}, 32'(obs[rd].width), 32'd2);
         rd++;
      end
   endtask
   task automatic wait_en();
      int i;
      i = 0;
      while (i < 400 && lcd_en !== 1'b1) begin
         @(negedge clk);
         i++;
      end
      chk("en_high_seen", 32'(lcd_en), 32'd1);
   endtask
   task automatic init_checks(input string tag);
      r = rd;
      next_strobe({tag, "_38"}, 1'b1);
      chk({tag, "_pwrup_quiet"}, 32'(obs[r].rise_cyc - rel_cyc >= 10), 32'd1);
      next_strobe({tag, "_0c"}, 1'b1);
      next_strobe({tag, "_06"}, 1'b1);
      next_strobe({tag, "_01"}, 1'b1);
   endtask
   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 12'h000;
      rom[0] = {4'b0011, 8'd4};
      rom[1] = {4'b0011, 8'd43};
      rom[2] = {4'b0011, 8'd90};
      rom[3] = {4'b0001, 8'h57};
      for (int i = 4; i < 20; i++) rom[i] = 12'h7AA;
      rom[20] = {4'b0100, 8'h00};
      rom[21] = 12'h000;
      run = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en", 32'(lcd_en), 32'd0);
      chk("rst_rs", 32'(lcd_rs), 32'd0);
      chk("rst_data", 32'(lcd_data), 32'd0);
      chk("rst_on", 32'(lcd_on), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_idx", cmd_idx, 32'd0);
      push(1'b0, 8'h38, 32'd0, 0);
      push(1'b0, 8'h0C, 32'd0, 5);
      push(1'b0, 8'h06, 32'd0, 5);
      push(1'b0, 8'h01, 32'd0, 5);
      push(1'b0, 8'h84, 32'd0, 20);
      push(1'b0, 8'hC3, 32'd1, 5);
      push(1'b0, 8'h80, 32'd2, 5);
      push(1'b1, 8'h57, 32'd3, 5);
      push(1'b0, 8'h01, 32'd21, 50);
      push(1'b0, 8'h84, 32'd0, 20);
      rst_n   = 1'b1;
      rel_cyc = cyc;
      repeat (2) @(negedge clk);
      chk("on_after_rst", 32'(lcd_on), 32'd1);
      chk("busy_pwrup", 32'(busy), 32'd1);
      chk("rw_tied", 32'(lcd_rw), 32'd0);
      init_checks("init1");
      next_strobe("setad4", 1'b1);
      next_strobe("setad43", 1'b1);
      next_strobe("setad90", 1'b1);
      next_strobe("write57", 1'b1);
      next_strobe("clear21", 1'b1);
      wait_en();
      #2 rst_n = 1'b0;
      #1;
      chk("abort_en", 32'(lcd_en), 32'd0);
      chk("abort_rs", 32'(lcd_rs), 32'd0);
      chk("abort_data", 32'(lcd_data), 32'd0);
      chk("abort_on", 32'(lcd_on), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      next_strobe("aborted84", 1'b0);
      for (int i = 0; i < 32; i++) rom[i] = 12'h000;
      rom[0] = {4'b0001, 8'h41};
      rom[1] = 12'h7FF;
      rom[2] = {4'b0001, 8'h42};
      push(1'b0, 8'h38, 32'd0, 0);
      push(1'b0, 8'h0C, 32'd0, 5);
      push(1'b0, 8'h06, 32'd0, 5);
      push(1'b0, 8'h01, 32'd0, 5);
      push(1'b1, 8'h41, 32'd0, 20);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rel_cyc = cyc;
      init_checks("init2");
      wait_en();
      run = 1'b0;
      next_strobe("write41", 1'b1);
      for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_idx", cmd_idx, 32'd1);
      @(posedge clk);
      #1 n0 = obs_n;
      repeat (10) @(posedge clk);
      #1;
      chk("frozen_idx", cmd_idx, 32'd1);
      chk("frozen_no_strobe", 32'(obs_n), 32'(n0));
      chk("frozen_busy", 32'(busy), 32'd0);
      push(1'b1, 8'h42, 32'd2, 5);
      push(1'b0, 8'h01, 32'd3, 5);
      run = 1'b1;
      repeat (3) @(negedge clk);
      chk("illegal_idx_before", cmd_idx, 32'd1);
      @(negedge clk);
      chk("illegal_idx_after", cmd_idx, 32'd2);
      next_strobe("write42", 1'b1);
      next_strobe("clear3", 1'b1);
      run = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
